// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb: round-robin arbiter feeding the register file's single write port from two one-entry buffers
module regfile_wr_arb #(
   parameter int AW = 5,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_valid0,
   input  logic [AW-1:0] i_addr0,
   input  logic [DW-1:0] i_data0,
   output logic          o_ready0,
   input  logic          i_valid1,
   input  logic [AW-1:0] i_addr1,
   input  logic [DW-1:0] i_data1,
   output logic          o_ready1,
   output logic [AW-1:0] o_wreg,
   output logic [DW-1:0] o_wdata,
   output logic          o_wen,
   input  logic [AW-1:0] i_chk_addr,
   output logic          o_chk_hit,
   output logic          o_grant
);
   logic          f0_q, f0_d, f1_q, f1_d, last_q, last_d;
   logic [AW-1:0] a0_q, a0_d, a1_q, a1_d;
   logic [DW-1:0] d0_q, d0_d, d1_q, d1_d;
   logic          g0, g1, acc0, acc1;

   // grant, write-port drive, readies and pending match, all from registered state
   always_comb begin
      g0        = f0_q & (~f1_q | last_q);
      g1        = f1_q & (~f0_q | ~last_q);
      o_wen     = f0_q | f1_q;
      o_grant   = g1;
      o_wreg    = g0 ? a0_q : g1 ? a1_q : '0;
      o_wdata   = g0 ? d0_q : g1 ? d1_q : '0;
      o_ready0  = ~f0_q | g0;
      o_ready1  = ~f1_q | g1;
      o_chk_hit = (f0_q & (a0_q == i_chk_addr)) | (f1_q & (a1_q == i_chk_addr));
   end

   // next state: granted entry retires, accepted non-r0 request refills its buffer
   always_comb begin
      acc0   = i_valid0 & o_ready0;
      acc1   = i_valid1 & o_ready1;
      f0_d   = acc0 ? |i_addr0 : f0_q & ~g0;
      f1_d   = acc1 ? |i_addr1 : f1_q & ~g1;
      a0_d   = (acc0 & |i_addr0) ? i_addr0 : a0_q;
      d0_d   = (acc0 & |i_addr0) ? i_data0 : d0_q;
      a1_d   = (acc1 & |i_addr1) ? i_addr1 : a1_q;
      d1_d   = (acc1 & |i_addr1) ? i_data1 : d1_q;
      last_d = o_wen ? g1 : last_q;
   end

   // state registers; reset empties both buffers and biases the first tie toward port 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         f0_q   <= 1'b0;
         f1_q   <= 1'b0;
         last_q <= 1'b1;
         a0_q   <= '0;
         a1_q   <= '0;
         d0_q   <= '0;
         d1_q   <= '0;
      end else begin
         f0_q   <= f0_d;
         f1_q   <= f1_d;
         last_q <= last_d;
         a0_q   <= a0_d;
         a1_q   <= a1_d;
         d0_q   <= d0_d;
         d1_q   <= d1_d;
      end
   end
endmodule

// File: doc/regfile_wr_arb.md
# regfile_wr_arb

Write-port arbiter for the 32 x 32 register file in the multi-cycle core. Two requesters, CPU writeback (port 0) and debug/loader (port 1), each post writes into a one-entry holding buffer. The arbiter drives the register file's single write port (write register, write data, write enable) from those buffers using round-robin. It also provides a pending-write match output so the control FSM can stall reads of a register whose write has not yet retired.

## Interface
- AW, 5, register address width
- DW, 32, register data width
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_valid0  in  1  port 0 (CPU) write request
- i_addr0  in  AW  port 0 destination register
- i_data0  in  DW  port 0 write data
- o_ready0  out  1  port 0 can accept this cycle
- i_valid1  in  1  port 1 (debug) write request
- i_addr1  in  AW  port 1 destination register
- i_data1  in  DW  port 1 write data
- o_ready1  out  1  port 1 can accept this cycle
- o_wreg  out  AW  to register file write address
- o_wdata  out  DW  to register file write data
- o_wen  out  1  to register file write enable
- i_chk_addr  in  AW  register address queried by control FSM
- o_chk_hit  out  1  a buffered, unretired write targets i_chk_addr
- o_grant  out  1  index of the port driving the write port this cycle (valid when o_wen=1)

## Operation
- Per-port state: full flag (f0, f1), buffered address, buffered data. One arbiter state bit, last, holds the index of the most recently granted port.
- Grant, combinational from registered state only:
  - only f0 set: port 0 granted.
  - only f1 set: port 1 granted.
  - both set: the port that is not last is granted.
  - neither set: no grant.
- Write port: o_wen = f0|f1. o_wreg/o_wdata come from the granted buffer. When o_wen=0, o_wreg/o_wdata = 0.
- Retire: at the clock edge, the granted buffer clears and last is set to the granted index. The register file captures the write on the same edge.
- Ready: o_readyN = ~fN | grantN. A new write can be accepted into a buffer on the edge that retires its old entry. No combinational path exists from i_valid to o_ready.
- Acceptance: on i_validN & o_readyN, the buffer loads addr/data and fN is set.
- Address-0 requests: accepted (handshake completes) but discarded. fN is cleared if it was retiring, and is never set by the r0 request.
- o_chk_hit = (f0 & addr_buf0==i_chk_addr) | (f1 & addr_buf1==i_chk_addr). Purely combinational. It is never set for i_chk_addr=0, since buffers never hold r0.
- Same-address writes from both ports retire in grant order; the later grant's data is final. Software and the debug path must not rely on cross-port ordering.
- Reset, asynchronous, also when asserted mid-operation:
  - f0=f1=0 and last=1 (port 0 wins the first tie).
  - Buffered addr/data are set to 0 and pending writes are dropped.
  - o_wen=0, o_ready0=o_ready1=1, o_chk_hit=0, o_grant=0, o_wreg=0, o_wdata=0, all immediately.

## Timing
- Accept at edge N. The entry drives the write port during cycle N..N+1. The register file holds the data after edge N+1 if the entry is granted; latency is 1 cycle uncontended.
- Under contention, worst-case extra wait is 1 cycle, because round-robin alternates.
- Sustained throughput: 1 write/cycle total. A single uncontended port sustains 1 write/cycle via retire-and-refill.
- o_chk_hit deasserts in the cycle after the matching entry retires.
- Outputs o_wen/o_wreg/o_wdata/o_grant depend only on flops and are glitch-free relative to requester inputs.

## Test plan
- Reset, then port 0 writes r5=0xDEADBEEF at edge 1:
  - o_wen=1, o_wreg=5, o_wdata=0xDEADBEEF, o_grant=0 during cycle 1–2.
  - o_chk_hit=1 for i_chk_addr=5 in that cycle, 0 in the next.
- Both ports valid every cycle (p0 → r1,r2,r3; p1 → r10,r11,r12):
  - o_wreg sequence is 1,10,2,11,3,12 with o_grant alternating 0,1,0,1,0,1.
  - Each ready is high only in the cycle its buffer is granted.
- Port 1 streams r20..r27 alone: o_ready1 stays 1, o_wen=1 for 8 consecutive cycles, and o_wreg increments by one each cycle.
- Port 0 writes r0=0xFFFFFFFF: the handshake completes and o_wen stays 0. Then r0 from both ports together: no write is issued and both readies stay 1.
- rst asserted mid-cycle with both buffers full: o_wen, o_chk_hit and o_grant drop to 0 without a clock edge, and no write is issued after release. The first tie after release grants port 0.
- Both ports write r7 (p0=0x1, p1=0x2) in the same cycle after reset: the grant order is p0 then p1, and a register file model shows r7=0x2 after 2 cycles.
